// File: rtl/dpram_pkg.sv
// Shared types and helpers for dual_port_ram.
// The stored word gains one parity bit when DPRAM_PARITY_EN is defined.
package dpram_pkg;

    typedef enum logic {INIT, RUN} state_t;

    // Widest data word that parity_even accepts; callers zero-extend into it.
    localparam int unsigned PARITY_MAX_W = 64;

`ifdef DPRAM_PARITY_EN
    localparam int unsigned STORE_EXTRA_BITS = 1;
`else
    localparam int unsigned STORE_EXTRA_BITS = 0;
`endif

    function automatic logic parity_even(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dpram_init_ctrl.sv
// Post-reset clear sequencer for dual_port_ram: walks every word once,
// then holds RUN and raises init_done.
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] count_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        clr_en    = 1'b0;
        clr_addr  = count;
        case (state)
            INIT: begin
                clr_en = 1'b1;
                if (count == LAST) begin
                    state_nxt = RUN;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign init_done = (state == RUN);

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with post-reset clear, A-wins write collisions and
// read-first semantics. Optional per-word parity via DPRAM_PARITY_EN.
module dual_port_ram
    import dpram_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_wr_rd,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]      a_wdata,
    output logic [WIDTH-1:0]      a_rdata,
    output logic                  a_rvalid,
    output logic                  a_perr,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_wr_rd,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]      b_wdata,
    output logic [WIDTH-1:0]      b_rdata,
    output logic                  b_rvalid,
    output logic                  b_perr,
    output logic                  init_done
);

    localparam int unsigned         SW      = WIDTH + STORE_EXTRA_BITS;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [SW-1:0] mem [DEPTH];

    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;

    dpram_init_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    function automatic logic [SW-1:0] pack_word(input logic [WIDTH-1:0] d);
`ifdef DPRAM_PARITY_EN
        logic [PARITY_MAX_W-1:0] ext;
        ext            = '0;
        ext[WIDTH-1:0] = d;
        return {parity_even(ext), d};
`else
        return d;
`endif
    endfunction

    assign a_ready = init_done;
    assign b_ready = init_done;

    logic a_in, b_in, a_wen, b_wen, a_ren, b_ren, b_wen_eff;

    assign a_in  = ({1'b0, a_addr} < DEPTH_L);
    assign b_in  = ({1'b0, b_addr} < DEPTH_L);
    assign a_wen = a_valid & a_ready & a_wr_rd & a_in;
    assign b_wen = b_valid & b_ready & b_wr_rd & b_in;
    assign a_ren = a_valid & a_ready & ~a_wr_rd;
    assign b_ren = b_valid & b_ready & ~b_wr_rd;
    // Port A owns an address both ports write in the same cycle.
    assign b_wen_eff = b_wen & ~(a_wen & (a_addr == b_addr));

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            if (a_wen) begin
                mem[a_addr] <= pack_word(a_wdata);
            end
            if (b_wen_eff) begin
                mem[b_addr] <= pack_word(b_wdata);
            end
        end
    end

    logic [SW-1:0] a_word, b_word;
    logic          a_bad, b_bad;

    assign a_word = mem[a_addr];
    assign b_word = mem[b_addr];

`ifdef DPRAM_PARITY_EN
    function automatic logic word_bad(input logic [SW-1:0] w);
        logic [PARITY_MAX_W-1:0] ext;
        ext            = '0;
        ext[WIDTH-1:0] = w[WIDTH-1:0];
        return parity_even(ext) != w[WIDTH];
    endfunction

    assign a_bad = word_bad(a_word);
    assign b_bad = word_bad(b_word);
`else
    assign a_bad = 1'b0;
    assign b_bad = 1'b0;
`endif

    // Reads sample the array before this edge's writes land: read-first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            a_perr   <= 1'b0;
        end else if (a_ren) begin
            a_rvalid <= 1'b1;
            a_rdata  <= a_in ? a_word[WIDTH-1:0] : '0;
            a_perr   <= a_in & a_bad;
        end else begin
            a_rvalid <= 1'b0;
            a_perr   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_perr   <= 1'b0;
        end else if (b_ren) begin
            b_rvalid <= 1'b1;
            b_rdata  <= b_in ? b_word[WIDTH-1:0] : '0;
            b_perr   <= b_in & b_bad;
        end else begin
            b_rvalid <= 1'b0;
            b_perr   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed vector table, random traffic
// against an array model, mid-stream reset, and parity corruption when enabled.
module tb_dual_port_ram;

    localparam int DEPTH = 16;
    localparam int W     = 8;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0, a_wr_rd = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [W-1:0]  a_wdata = '0;
    logic          b_valid = 1'b0, b_wr_rd = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [W-1:0]  b_wdata = '0;
    logic          a_ready, a_rvalid, a_perr, b_ready, b_rvalid, b_perr, init_done;
    logic [W-1:0]  a_rdata, b_rdata;

    dual_port_ram #(.DEPTH(DEPTH), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_wr_rd(a_wr_rd), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_perr(a_perr),
        .b_valid(b_valid), .b_ready(b_ready), .b_wr_rd(b_wr_rd), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_perr(b_perr),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: word contents, cycles since reset release, last read data.
    logic [W-1:0] ref_mem [DEPTH];
    int           rel_cnt;
    logic [W-1:0] m_a_rdata, m_b_rdata;
    logic         m_a_rvalid, m_b_rvalid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rel_cnt   = 0;
        m_a_rdata = '0;
        m_b_rdata = '0;
    endtask

    // One clock of traffic on both ports, checked against the model.
    task automatic step(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                        input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [W-1:0] bd);
        logic rdy;
        a_valid = av; a_wr_rd = aw; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_wr_rd = bw; b_addr = ba; b_wdata = bd;
        rdy = (rel_cnt >= DEPTH);
        chk("a_ready", 32'(a_ready), 32'(rdy));
        chk("b_ready", 32'(b_ready), 32'(rdy));
        m_a_rvalid = rdy && av && !aw;
        m_b_rvalid = rdy && bv && !bw;
        if (m_a_rvalid) m_a_rdata = (int'(aa) < DEPTH) ? ref_mem[aa] : '0;
        if (m_b_rvalid) m_b_rdata = (int'(ba) < DEPTH) ? ref_mem[ba] : '0;
        if (rdy) begin
            if (bv && bw && int'(ba) < DEPTH && !(av && aw && aa == ba)) ref_mem[ba] = bd;
            if (av && aw && int'(aa) < DEPTH) ref_mem[aa] = ad;
        end
        @(posedge clk); #1;
        rel_cnt++;
        chk("a_rvalid", 32'(a_rvalid), 32'(m_a_rvalid));
        chk("a_rdata",  32'(a_rdata),  32'(m_a_rdata));
        chk("a_perr",   32'(a_perr),   32'd0);
        chk("b_rvalid", 32'(b_rvalid), 32'(m_b_rvalid));
        chk("b_rdata",  32'(b_rdata),  32'(m_b_rdata));
        chk("b_perr",   32'(b_perr),   32'd0);
        chk("init_done", 32'(init_done), 32'(rel_cnt >= DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    typedef struct {
        logic          av, aw;
        logic [AW-1:0] aa;
        logic [W-1:0]  ad;
        logic          bv, bw;
        logic [AW-1:0] ba;
        logic [W-1:0]  bd;
        logic          ea_v;
        logic [W-1:0]  ea_d;
        logic          eb_v;
        logic [W-1:0]  eb_d;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1, 0, 4'd0,  8'h00, 1, 0, 4'd15, 8'h00, 1, 8'h00, 1, 8'h00};
        tbl[1]  = '{1, 1, 4'd3,  8'h5A, 0, 0, 4'd0,  8'h00, 0, 8'h00, 0, 8'h00};
        tbl[2]  = '{0, 0, 4'd0,  8'h00, 1, 0, 4'd3,  8'h00, 0, 8'h00, 1, 8'h5A};
        tbl[3]  = '{1, 1, 4'd7,  8'h11, 1, 1, 4'd7,  8'h22, 0, 8'h00, 0, 8'h5A};
        tbl[4]  = '{1, 0, 4'd7,  8'h00, 1, 0, 4'd7,  8'h00, 1, 8'h11, 1, 8'h11};
        tbl[5]  = '{1, 1, 4'd2,  8'h33, 0, 0, 4'd0,  8'h00, 0, 8'h11, 0, 8'h11};
        tbl[6]  = '{1, 1, 4'd2,  8'h44, 1, 0, 4'd2,  8'h00, 0, 8'h11, 1, 8'h33};
        tbl[7]  = '{0, 0, 4'd0,  8'h00, 1, 0, 4'd2,  8'h00, 0, 8'h11, 1, 8'h44};
        tbl[8]  = '{1, 0, 4'd2,  8'h00, 1, 1, 4'd2,  8'h55, 1, 8'h44, 0, 8'h44};
        tbl[9]  = '{1, 0, 4'd2,  8'h00, 1, 0, 4'd2,  8'h00, 1, 8'h55, 1, 8'h55};
        tbl[10] = '{1, 1, 4'd9,  8'hC3, 1, 0, 4'd9,  8'h00, 0, 8'h55, 1, 8'h00};
        tbl[11] = '{1, 0, 4'd9,  8'h00, 1, 0, 4'd15, 8'h00, 1, 8'hC3, 1, 8'h00};

        model_reset();
        #2;
        chk("rst_a_rdata",  32'(a_rdata),  32'd0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_a_ready",  32'(a_ready),  32'd0);
        chk("rst_b_ready",  32'(b_ready),  32'd0);
        chk("rst_perr",     32'({a_perr, b_perr}), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Clear sequence; a request mid-INIT must be ignored.
        idle(5);
        step(1, 1, 4'd1, 8'hEE, 1, 1, 4'd2, 8'hDD);
        idle(DEPTH - 6);
        chk("init_done_edge16", 32'(init_done), 32'd1);

        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(i), '0, 1, 0, AW'(DEPTH - 1 - i), '0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].av, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].bw, tbl[i].ba, tbl[i].bd);
            chk($sformatf("vec%0d_a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].ea_v));
            chk($sformatf("vec%0d_a_rdata", i),  32'(a_rdata),  32'(tbl[i].ea_d));
            chk($sformatf("vec%0d_b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].eb_v));
            chk($sformatf("vec%0d_b_rdata", i),  32'(b_rdata),  32'(tbl[i].eb_d));
        end

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            step(1'($urandom), 1'($urandom), ra, W'($urandom),
                 1'($urandom), 1'($urandom), rb, W'($urandom));
        end

        // Mid-stream reset during back-to-back reads.
        step(1, 1, 4'd3, 8'hA5, 1, 1, 4'd7, 8'h5C);
        step(1, 0, 4'd3, '0, 1, 0, 4'd7, '0);
        a_valid = 1; a_wr_rd = 0; a_addr = 4'd7;
        b_valid = 1; b_wr_rd = 0; b_addr = 4'd3;
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("mid_rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("mid_rst_a_rdata",  32'(a_rdata),  32'd0);
        chk("mid_rst_ready",    32'(a_ready),  32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        step(1, 0, 4'd3, '0, 1, 0, 4'd7, '0);
        idle(DEPTH - 1);
        step(1, 0, 4'd3, '0, 1, 0, 4'd7, '0);
        chk("post_rst_a_rdata", 32'(a_rdata), 32'd0);
        chk("post_rst_b_rdata", 32'(b_rdata), 32'd0);

`ifdef DPRAM_PARITY_EN
        step(1, 1, 4'd5, 8'h0F, 0, 0, '0, '0);
        dut.mem[5][0] = ~dut.mem[5][0];
        ref_mem[5] = 8'h0E;
        a_valid = 1; a_wr_rd = 0; a_addr = 4'd5; b_valid = 0;
        @(posedge clk); #1;
        rel_cnt++;
        m_a_rdata = 8'h0E;
        chk("par_rvalid", 32'(a_rvalid), 32'd1);
        chk("par_rdata",  32'(a_rdata),  32'h0E);
        chk("par_perr",   32'(a_perr),   32'd1);
        step(1, 0, 4'd6, '0, 0, 0, '0, '0);
        chk("par_clean_perr", 32'(a_perr), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

Parametrised true dual-port RAM, the successor to our single-port valid/ready RAM. It provides two independent request ports, A and B, that share one storage array. Each port can read or write on every cycle. The block adds an automatic post-reset clear sequence, defined write-collision and read-during-write rules, and optional per-word parity. It sits between two bus masters, e.g. a producer engine and a CPU register window, that need concurrent access to the same buffer.

## Interface
Parameters:
- DEPTH, 16, number of words
- WIDTH, 8, data bits per word
- ADDR_WIDTH, 4, address bits; must satisfy 2**ADDR_WIDTH >= DEPTH

Ports (p = a or b; one identical set per port):
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous reset, active-low
- p_valid  in  1  request present
- p_ready  out  1  port can accept a request this cycle
- p_wr_rd  in  1  1 = write, 0 = read
- p_addr  in  ADDR_WIDTH  word address
- p_wdata  in  WIDTH  write data
- p_rdata  out  WIDTH  read data
- p_rvalid  out  1  one-cycle pulse: p_rdata is valid
- p_perr  out  1  parity error on the returned read data (see Configuration)
- init_done  out  1  high once the memory clear sequence has completed

## Operation
- States: INIT and RUN. rst low forces INIT with clear counter = 0.
- INIT:
  - Writes 0 to word[counter] and increments the counter once per cycle.
  - After the write of word DEPTH-1 at edge N, the block enters RUN and init_done rises at edge N.
  - a_ready and b_ready are held at 0; requests are ignored.
- RUN:
  - p_ready = 1 constantly.
  - A request is accepted on a rising edge with p_valid & p_ready.
- Write: word[p_addr] <= p_wdata at the accepting edge.
- Read:
  - Samples word[p_addr] at the accepting edge.
  - p_rdata and p_rvalid update on that same edge and are visible during the next cycle.
- Same-address write collision (A and B both write one address in the same cycle): port A wins and B's write is dropped.
- Read-during-write, same address, either port combination: read-first. The read returns the old contents. The new data is visible to reads accepted one cycle later or after.
- Out-of-range address (p_addr >= DEPTH):
  - Writes are dropped.
  - Reads return 0 with p_rvalid = 1 and p_perr = 0.
- p_rdata holds its last value when p_rvalid = 0.

## Timing
- Reset values: p_rdata = 0, p_rvalid = 0, p_ready = 0, p_perr = 0, init_done = 0.
- Clear sequence: DEPTH cycles after rst deasserts. The first request is accepted at cycle DEPTH+1.
- Read latency: 1 cycle. Throughput: 1 request per port per cycle.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs return to reset values immediately.
  - Any in-flight read response is discarded.
  - The clear sequence restarts from word 0.

## Configuration
- DPRAM_PARITY_EN defined:
  - Storage is WIDTH+1 bits per word; the extra bit holds even parity of the data.
  - INIT writes parity 0.
  - On read, p_perr = 1 in the p_rvalid cycle if the recomputed parity does not match the stored bit.
  - Data is returned uncorrected.
- DPRAM_PARITY_EN undefined: storage is WIDTH bits; p_perr is tied to 0. Port list is unchanged.

## Structure
- Package dpram_pkg:
  - State enum {INIT, RUN}.
  - Function parity_even(data).
  - Localparam for the stored word width, which depends on the macro.
- Sub-module dpram_init_ctrl: INIT/RUN state machine, clear counter, init_done, and the clear-write address/enable. The top level muxes the clear write ahead of the port-A write path.
- The top level holds the array, both port datapaths, and the collision/read-first logic.

## Test plan
- Reset then idle: rst low for 3 cycles, then release; DEPTH=16. Expect a_ready = 0 for 16 cycles, init_done = 1 after edge 16, and reads of addresses 0..15 all return 0x00.
- Basic R/W:
  - A writes 0x5A to address 3; next cycle B reads address 3.
  - Expect b_rvalid one cycle later with b_rdata = 0x5A.
- Collision: A writes 0x11 and B writes 0x22 to address 7 in the same cycle, then read address 7. Expect 0x11.
- Read-first:
  - Address 2 holds 0x33. A writes 0x44 to address 2 while B reads address 2 in the same cycle. Expect b_rdata = 0x33.
  - The next B read of address 2 returns 0x44.
- Reset mid-stream:
  - Assert rst during back-to-back reads. Expect p_rvalid = 0 immediately and a full clear cycle after release.
  - Previously written data must read 0.
- Parity (DPRAM_PARITY_EN defined):
  - Write 0x0F to address 5, then force-flip stored bit 0.
  - Read address 5: expect rdata = 0x0E with a_perr = 1 for one cycle.
  - A clean word reads with a_perr = 0.
